// File: rtl/pcie_dll_pkg.sv
// Shared data link layer types: FSM states, DLLP source classes, CRC seed and bit reversal.
package pcie_dll_pkg;

    typedef enum logic [1:0] {IDLE, CRC, SEND} state_e;
    typedef enum logic [1:0] {SRC_ACK, SRC_FC, SRC_PM} src_e;

    localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;
    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pcie_dllp_crc8.sv
// One-byte step of the DLLP CRC16 (poly 0x100B); data bits are consumed LSB first.
module pcie_dllp_crc8 (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);
    import pcie_dll_pkg::*;

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[15]) begin
                c = {c[14:0], 1'b0} ^ DLLP_CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/pcie_dllp_tx_scheduler.sv
// DLLP TX scheduler: arbitrates Ack/Nak, UpdateFC and PM, appends CRC16, emits 6-byte DLLPs.
// Optional sent-DLLP statistics counters are built when PCIE_DLLP_TX_STATS_EN is defined.
module pcie_dllp_tx_scheduler #(
    parameter int unsigned FC_STARVE_LIMIT = 4
`ifdef PCIE_DLLP_TX_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_ack_tdata,
    input  logic        s_ack_tvalid,
    output logic        s_ack_tready,
    input  logic [31:0] s_fc_tdata,
    input  logic        s_fc_tvalid,
    output logic        s_fc_tready,
    input  logic [31:0] s_pm_tdata,
    input  logic        s_pm_tvalid,
    output logic        s_pm_tready,
    output logic [47:0] m_dllp_tdata,
    output logic        m_dllp_tvalid,
    input  logic        m_dllp_tready,
    output logic        busy
`ifdef PCIE_DLLP_TX_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ack,
    output logic [STAT_W-1:0] stat_fc,
    output logic [STAT_W-1:0] stat_pm
`endif
);
    import pcie_dll_pkg::*;

    localparam int unsigned SW = $clog2(FC_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FC_STARVE_LIMIT);

    state_e      state_q;
    logic [31:0] content_q;
    logic [15:0] crc_q;
    logic [15:0] crc_next;
    logic [1:0]  cnt_q;
    logic [SW-1:0] starve_q;
    logic        rr_fc_q;    // FC wins an FC/PM tie when set
    logic [7:0]  crc_byte;
    logic        grant;
    src_e        grant_src;

    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_ACK;
        if (state_q == IDLE && !rst) begin
            if (s_fc_tvalid && starve_q == STARVE_MAX) begin
                grant     = 1'b1;
                grant_src = SRC_FC;
            end else if (s_ack_tvalid) begin
                grant     = 1'b1;
                grant_src = SRC_ACK;
            end else if (s_fc_tvalid && (rr_fc_q || !s_pm_tvalid)) begin
                grant     = 1'b1;
                grant_src = SRC_FC;
            end else if (s_pm_tvalid) begin
                grant     = 1'b1;
                grant_src = SRC_PM;
            end
        end
    end

    assign s_ack_tready = grant && (grant_src == SRC_ACK);
    assign s_fc_tready  = grant && (grant_src == SRC_FC);
    assign s_pm_tready  = grant && (grant_src == SRC_PM);

    always_comb begin
        unique case (cnt_q)
            2'd0:    crc_byte = content_q[7:0];
            2'd1:    crc_byte = content_q[15:8];
            2'd2:    crc_byte = content_q[23:16];
            default: crc_byte = content_q[31:24];
        endcase
    end

    pcie_dllp_crc8 u_crc8 (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            content_q     <= '0;
            crc_q         <= DLLP_CRC_SEED;
            cnt_q         <= '0;
            starve_q      <= '0;
            rr_fc_q       <= 1'b1;
            m_dllp_tvalid <= 1'b0;
            m_dllp_tdata  <= '0;
            busy          <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= CRC;
                        busy    <= 1'b1;
                        crc_q   <= DLLP_CRC_SEED;
                        cnt_q   <= '0;
                        unique case (grant_src)
                            SRC_ACK: begin
                                content_q <= s_ack_tdata;
                                if (s_fc_tvalid && starve_q != STARVE_MAX) begin
                                    starve_q <= starve_q + SW'(1);
                                end
                            end
                            SRC_FC: begin
                                content_q <= s_fc_tdata;
                                starve_q  <= '0;
                                rr_fc_q   <= ~rr_fc_q;
                            end
                            SRC_PM: begin
                                content_q <= s_pm_tdata;
                                rr_fc_q   <= ~rr_fc_q;
                            end
                            default: ;
                        endcase
                    end
                end
                CRC: begin
                    crc_q <= crc_next;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q       <= SEND;
                        m_dllp_tvalid <= 1'b1;
                        m_dllp_tdata  <= {bitrev8(~crc_next[7:0]), bitrev8(~crc_next[15:8]),
                                          content_q};
                    end
                end
                SEND: begin
                    if (m_dllp_tready) begin
                        state_q       <= IDLE;
                        m_dllp_tvalid <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PCIE_DLLP_TX_STATS_EN
    src_e src_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= SRC_ACK;
            stat_ack <= '0;
            stat_fc  <= '0;
            stat_pm  <= '0;
        end else begin
            if (grant) begin
                src_q <= grant_src;
            end
            if (state_q == SEND && m_dllp_tvalid && m_dllp_tready) begin
                unique case (src_q)
                    SRC_ACK: stat_ack <= stat_ack + 1'b1;
                    SRC_FC:  stat_fc  <= stat_fc + 1'b1;
                    SRC_PM:  stat_pm  <= stat_pm + 1'b1;
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcie_dllp_tx_scheduler.sv
// Scoreboard bench for pcie_dllp_tx_scheduler; stats checks run when PCIE_DLLP_TX_STATS_EN is set.
module tb_pcie_dllp_tx_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] s_ack_tdata, s_fc_tdata, s_pm_tdata;
    logic        s_ack_tvalid, s_fc_tvalid, s_pm_tvalid;
    logic        s_ack_tready, s_fc_tready, s_pm_tready;
    logic [47:0] m_dllp_tdata;
    logic        m_dllp_tvalid;
    logic        m_dllp_tready;
    logic        busy;
`ifdef PCIE_DLLP_TX_STATS_EN
    logic [15:0] stat_ack, stat_fc, stat_pm;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] ackq[$];
    logic [31:0] fcq[$];
    logic [31:0] pmq[$];
    logic [47:0] exp_q[$];
    int          exp_g[$];

    pcie_dllp_tx_scheduler #(
        .FC_STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_ack_tdata   (s_ack_tdata),
        .s_ack_tvalid  (s_ack_tvalid),
        .s_ack_tready  (s_ack_tready),
        .s_fc_tdata    (s_fc_tdata),
        .s_fc_tvalid   (s_fc_tvalid),
        .s_fc_tready   (s_fc_tready),
        .s_pm_tdata    (s_pm_tdata),
        .s_pm_tvalid   (s_pm_tvalid),
        .s_pm_tready   (s_pm_tready),
        .m_dllp_tdata  (m_dllp_tdata),
        .m_dllp_tvalid (m_dllp_tvalid),
        .m_dllp_tready (m_dllp_tready),
        .busy          (busy)
`ifdef PCIE_DLLP_TX_STATS_EN
        ,
        .stat_ack      (stat_ack),
        .stat_fc       (stat_fc),
        .stat_pm       (stat_pm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Golden DLLP: bit-serial CRC16 over all 32 content bits, LSB of byte0 first.
    function automatic logic [47:0] model(input logic [31:0] c);
        logic [15:0] r;
        logic [15:0] f;
        logic [7:0]  hi, lo;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb = c[i] ^ r[15];
            r  = r << 1;
            if (fb) r = r ^ 16'h100B;
        end
        f = ~r;
        for (int k = 0; k < 8; k++) begin
            hi[k] = f[15-k];
            lo[k] = f[7-k];
        end
        return {lo, hi, c};
    endfunction

    // Source driver: each queue head is presented until its accept pulse is seen.
    always begin
        logic [2:0] acc;
        @(negedge clk);
        acc = {s_pm_tready, s_fc_tready, s_ack_tready};
        @(posedge clk);
        #1;
        if (acc[0] && ackq.size() > 0) void'(ackq.pop_front());
        if (acc[1] && fcq.size() > 0) void'(fcq.pop_front());
        if (acc[2] && pmq.size() > 0) void'(pmq.pop_front());
        s_ack_tvalid = (ackq.size() > 0);
        s_ack_tdata  = (ackq.size() > 0) ? ackq[0] : 32'h0;
        s_fc_tvalid  = (fcq.size() > 0);
        s_fc_tdata   = (fcq.size() > 0) ? fcq[0] : 32'h0;
        s_pm_tvalid  = (pmq.size() > 0);
        s_pm_tdata   = (pmq.size() > 0) ? pmq[0] : 32'h0;
    end

    // Monitor: grant order and delivered DLLPs against the scoreboard queues.
    always @(negedge clk) begin
        logic [2:0] r;
        int g;
        r = {s_pm_tready, s_fc_tready, s_ack_tready};
        if (r != 3'b000) begin
            if (exp_g.size() == 0) begin
                check("grant_unexpected", {61'd0, r}, 64'd0);
            end else begin
                g = exp_g.pop_front();
                check("grant_order", {61'd0, r}, 64'd1 << g);
            end
        end
        if (m_dllp_tvalid && m_dllp_tready) begin
            if (exp_q.size() == 0) begin
                check("dllp_unexpected", {16'd0, m_dllp_tdata}, 64'd0);
            end else begin
                check("dllp_data", {16'd0, m_dllp_tdata}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input int s, input logic [31:0] c);
        exp_g.push_back(s);
        exp_q.push_back(model(c));
        case (s)
            0:       ackq.push_back(c);
            1:       fcq.push_back(c);
            default: pmq.push_back(c);
        endcase
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_g.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size() + exp_g.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_tvalid"}, {63'd0, m_dllp_tvalid}, 64'd0);
        check({name, "_tdata"}, {16'd0, m_dllp_tdata}, 64'd0);
        check({name, "_treadys"}, {61'd0, s_pm_tready, s_fc_tready, s_ack_tready}, 64'd0);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs(name);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        int t0;
        rst = 1'b1;
        m_dllp_tready = 1'b0;
        s_ack_tvalid = 1'b0; s_fc_tvalid = 1'b0; s_pm_tvalid = 1'b0;
        s_ack_tdata = '0; s_fc_tdata = '0; s_pm_tdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single Ack, latency grant->tvalid is 5 cycles
        m_dllp_tready = 1'b1;
        send(0, 32'h0000_0000);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ack_tready && n < 20);
        check("t1_grant_seen", {63'd0, s_ack_tready}, 64'd1);
        t0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_dllp_tvalid && n < 20);
        check("t1_latency", 64'(cyc - t0), 64'd5);
        drain("t1_drain");

        // 2: FC with downstream stalled for 10 cycles
        @(posedge clk);
        #1 m_dllp_tready = 1'b0;
        send(1, 32'h8012_3456);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_dllp_tvalid && n < 20);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_tvalid", {63'd0, m_dllp_tvalid}, 64'd1);
            check("t2_hold_tdata", {16'd0, m_dllp_tdata}, {16'd0, model(32'h8012_3456)});
            check("t2_hold_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 m_dllp_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_busy_drop", {63'd0, busy}, 64'd0);
        check("t2_tvalid_drop", {63'd0, m_dllp_tvalid}, 64'd0);
        drain("t2_drain");

        // 3: all three valid at once -> Ack, FC, PM
        do_reset("t3_reset");
        send(0, 32'hA5A5_0001);
        send(1, 32'h4000_00FF);
        send(2, 32'h2000_0000);
        drain("t3_drain");

        // 4: Ack held valid with FC pending -> four Acks, forced FC, then Ack resumes
        for (int i = 0; i < 4; i++) send(0, 32'h0000_0010 + i);
        send(1, 32'h6000_1234);
        send(0, 32'h0000_0020);
        send(0, 32'h0000_0021);
        drain("t4_drain");

        // 5: reset during CRC aborts the DLLP
        exp_g.push_back(0);
        ackq.push_back(32'hCAFE_0001);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ack_tready && n < 20);
        check("t5_grant_seen", {63'd0, s_ack_tready}, 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("t5_abort");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_no_output", {63'd0, m_dllp_tvalid}, 64'd0);
        send(0, 32'hDEAD_BEEF);
        drain("t5_drain");

`ifdef PCIE_DLLP_TX_STATS_EN
        // 6: statistics per class
        do_reset("t6_reset");
        check("t6_stat_zero", {16'd0, stat_ack, stat_fc, stat_pm}, 64'd0);
        for (int i = 0; i < 3; i++) begin send(0, 32'h0000_0100 + i); drain("t6_ack"); end
        for (int i = 0; i < 2; i++) begin send(1, 32'h0000_0200 + i); drain("t6_fc"); end
        send(2, 32'h0000_0300);
        drain("t6_pm");
        check("t6_stat_ack", 64'(stat_ack), 64'd3);
        check("t6_stat_fc", 64'(stat_fc), 64'd2);
        check("t6_stat_pm", 64'(stat_pm), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
